// File: rtl/app_stream_source.sv
// Application image streamer: walks a descriptor table in synchronous ROM and releases each image at its start cycle.
// Define APP_STREAM_SOURCE_STATS_EN to add the stall_cycles_o / words_sent_o statistics outputs.
module app_stream_source #(
    parameter int ADDR_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [31:0]           mem_data_i,
    output logic                  src_rx_o,
    input  logic                  src_credit_i,
    output logic [31:0]           src_data_o,
    output logic                  src_eoa_o,
    output logic                  busy_o
`ifdef APP_STREAM_SOURCE_STATS_EN
    ,
    output logic [31:0]           stall_cycles_o,
    output logic [31:0]           words_sent_o
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

    typedef enum logic [2:0] {
        IDLE, RD_COUNT, RD_ENTRY, WAIT_TIME, STREAM, NEXT, DONE
    } state_t;

    state_t                state_r, state_s;
    logic [1:0]            phase_r;
    logic [31:0]           cycle_r;
    logic [31:0]           app_cnt_r;
    logic [31:0]           app_idx_r;
    logic [31:0]           start_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic                  rd_vld_r;
    logic [32:0]           issued_r;
    logic [32:0]           total_r;
    logic [32:0]           sent_r;
    logic                  len_known_r;
    logic [31:0]           fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]      fifo_cnt_r;

    logic [ADDR_WIDTH-1:0] entry_addr_s;
    logic                  in_stream_s;
    logic                  first_ret_s;
    logic [32:0]           total_s;
    logic [CNT_W:0]        occ_s;
    logic                  issue_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  last_pop_s;

    assign entry_addr_s = {app_idx_r[ADDR_WIDTH-2:0], 1'b1};
    assign in_stream_s  = (state_r == STREAM);
    assign first_ret_s  = in_stream_s && rd_vld_r && !len_known_r;
    assign occ_s        = {1'b0, fifo_cnt_r} + {{CNT_W{1'b0}}, rd_vld_r};
    assign push_s       = in_stream_s && rd_vld_r;
    assign pop_s        = src_rx_o && src_credit_i;
    assign last_pop_s   = pop_s && ((sent_r + 33'd1) == total_r);

    // Image word budget: only one read is safe until the length word returns
    always_comb begin
        total_s = 33'd1;
        if (len_known_r) begin
            total_s = total_r;
        end else if (first_ret_s) begin
            total_s = {1'b0, mem_data_i} + 33'd1;
        end else begin
            total_s = 33'd1;
        end
    end

    assign issue_s = in_stream_s && (issued_r < total_s) && (occ_s < DEPTH_C);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and memory request decode
    always_comb begin
        state_s    = state_r;
        mem_en_o   = 1'b0;
        mem_addr_o = {ADDR_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_s = RD_COUNT;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_COUNT: begin
                if (phase_r == 2'd0) begin
                    mem_en_o = 1'b1;
                end else if (mem_data_i == 32'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = RD_ENTRY;
                end
            end
            RD_ENTRY: begin
                if (phase_r == 2'd0) begin
                    mem_en_o   = 1'b1;
                    mem_addr_o = entry_addr_s;
                end else if (phase_r == 2'd1) begin
                    mem_en_o   = 1'b1;
                    mem_addr_o = entry_addr_s + ADDR_WIDTH'(1'b1);
                end else begin
                    state_s = WAIT_TIME;
                end
            end
            WAIT_TIME: begin
                if (cycle_r >= start_r) begin
                    state_s = STREAM;
                end else begin
                    state_s = WAIT_TIME;
                end
            end
            STREAM: begin
                mem_en_o   = issue_s;
                mem_addr_o = base_r + issued_r[ADDR_WIDTH-1:0];
                if (last_pop_s) begin
                    state_s = NEXT;
                end else begin
                    state_s = STREAM;
                end
            end
            NEXT: begin
                if ((app_idx_r + 32'd1) == app_cnt_r) begin
                    state_s = DONE;
                end else begin
                    state_s = RD_ENTRY;
                end
            end
            DONE: begin
                state_s = DONE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sub-step counter for multi-cycle table reads, restarted on every state change
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_r <= 2'd0;
        end else if (state_s != state_r) begin
            phase_r <= 2'd0;
        end else if (phase_r != 2'd3) begin
            phase_r <= phase_r + 2'd1;
        end else begin
            phase_r <= phase_r;
        end
    end

    // Saturating free-running cycle counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_r <= 32'd0;
        end else if (cycle_r != 32'hFFFF_FFFF) begin
            cycle_r <= cycle_r + 32'd1;
        end else begin
            cycle_r <= cycle_r;
        end
    end

    // Table field capture and application index
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            app_cnt_r <= 32'd0;
            app_idx_r <= 32'd0;
            start_r   <= 32'd0;
            base_r    <= {ADDR_WIDTH{1'b0}};
        end else begin
            if (state_r == RD_COUNT && phase_r == 2'd1) begin
                app_cnt_r <= mem_data_i;
                app_idx_r <= 32'd0;
            end
            if (state_r == RD_ENTRY && phase_r == 2'd1) begin
                start_r <= mem_data_i;
            end
            if (state_r == RD_ENTRY && phase_r == 2'd2) begin
                base_r <= mem_data_i[ADDR_WIDTH-1:0];
            end
            if (state_r == NEXT) begin
                app_idx_r <= app_idx_r + 32'd1;
            end
        end
    end

    // Read-data valid tracker: synchronous ROM answers one cycle after the request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_r <= 1'b0;
        end else begin
            rd_vld_r <= mem_en_o;
        end
    end

    // Per-image request/length/handshake bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_r    <= 33'd0;
            total_r     <= 33'd0;
            sent_r      <= 33'd0;
            len_known_r <= 1'b0;
        end else if (!in_stream_s) begin
            issued_r    <= 33'd0;
            total_r     <= 33'd0;
            sent_r      <= 33'd0;
            len_known_r <= 1'b0;
        end else begin
            if (mem_en_o) begin
                issued_r <= issued_r + 33'd1;
            end
            if (first_ret_s) begin
                total_r     <= total_s;
                len_known_r <= 1'b1;
            end
            if (pop_s) begin
                sent_r <= sent_r + 33'd1;
            end
        end
    end

    // Prefetch FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
        end else if (!in_stream_s) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1'b1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1'b1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Prefetch FIFO storage
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= mem_data_i;
        end
    end

    assign src_rx_o   = in_stream_s && (fifo_cnt_r != {CNT_W{1'b0}});
    assign src_data_o = src_rx_o ? fifo_mem_r[rd_ptr_r] : 32'd0;
    assign src_eoa_o  = (state_r == DONE);
    assign busy_o     = (state_r != IDLE) && (state_r != DONE);

`ifdef APP_STREAM_SOURCE_STATS_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] words_sent_r;

    // Saturating stall and throughput statistics
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_r <= 32'd0;
            words_sent_r   <= 32'd0;
        end else begin
            if (src_rx_o && !src_credit_i && stall_cycles_r != 32'hFFFF_FFFF) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (pop_s && words_sent_r != 32'hFFFF_FFFF) begin
                words_sent_r <= words_sent_r + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_r;
    assign words_sent_o   = words_sent_r;
`endif

endmodule
